// File: rtl/fifo_wr_ptr_gray.sv
// Async FIFO write-side pointer logic: binary/Gray write pointer, full, fill level, overflow.
// Optional almost-full output when FIFO_WR_ALMOST_FULL_EN is defined.
module fifo_wr_ptr_gray #(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  wr_req_in,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray_in,
  output logic                  wr_en_out,
  output logic [ADDR_WIDTH-1:0] wr_addr_out,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray_out,
  output logic                  full_out,
  output logic [ADDR_WIDTH:0]   fill_level_out,
`ifdef FIFO_WR_ALMOST_FULL_EN
  output logic                  almost_full_out,
`endif
  output logic                  overflow_out
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  // Full when the read pointer is one lap behind: top two Gray bits inverted.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] gray_next;
  logic [PW-1:0] rbin;
  logic [PW-1:0] fill_next;
  logic          full_next;

  assign wr_en_out   = wr_req_in & ~full_out & ~rst_in;
  assign wr_addr_out = wbin[ADDR_WIDTH-1:0];

  always_comb begin
    rbin = '0;
    for (int i = 0; i < PW; i++) begin
      rbin[i] = ^(rd_ptr_gray_in >> i);
    end
  end

  always_comb begin
    wbin_next = wbin + PW'(wr_en_out);
    gray_next = (wbin_next >> 1) ^ wbin_next;
    full_next = (gray_next == (rd_ptr_gray_in ^ FULL_MASK));
    fill_next = wbin_next - rbin;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wbin            <= '0;
      wr_ptr_gray_out <= '0;
      full_out        <= 1'b0;
      fill_level_out  <= '0;
      overflow_out    <= 1'b0;
    end else begin
      wbin            <= wbin_next;
      wr_ptr_gray_out <= gray_next;
      full_out        <= full_next;
      fill_level_out  <= fill_next;
      overflow_out    <= overflow_out | (wr_req_in & full_out);
    end
  end

`ifdef FIFO_WR_ALMOST_FULL_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      almost_full_out <= 1'b0;
    end else begin
      almost_full_out <= (fill_next >= PW'(DEPTH - AF_THRESH));
    end
  end
`endif

endmodule

// File: doc/fifo_wr_ptr_gray.md
FIFO_WR_PTR_GRAY -- requirements
Module: fifo_wr_ptr_gray

Interface
REQ-001 Parameter ADDR_WIDTH, default 4: FIFO RAM address width; depth = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
REQ-002 Parameter AF_THRESH, default 2: almost-full margin in entries; legal range is 1 to 2^ADDR_WIDTH-1.
REQ-003 clk_in  input  1  sole clock, the write domain.
REQ-004 rst_in  input  1  reset, synchronous to clk_in, active-high.
REQ-005 wr_req_in  input  1  producer write request.
REQ-006 rd_ptr_gray_in  input  ADDR_WIDTH+1  read pointer in Gray code, already synchronized into clk_in by a 2-flop Gray CDC.
REQ-007 wr_en_out  output  1  accepted-write strobe to the RAM write port.
REQ-008 wr_addr_out  output  ADDR_WIDTH  RAM write address, the low bits of the binary write pointer.
REQ-009 wr_ptr_gray_out  output  ADDR_WIDTH+1  registered Gray write pointer, sent to the read-side synchronizer.
REQ-010 full_out  output  1  FIFO full, registered.
REQ-011 fill_level_out  output  ADDR_WIDTH+1  conservative occupancy, registered.
REQ-012 overflow_out  output  1  sticky error flag, set by a write attempted while full.
REQ-013 almost_full_out  output  1  present only when FIFO_WR_ALMOST_FULL_EN is defined.

Function
REQ-014 wr_en_out SHALL equal wr_req_in AND NOT full_out, combinationally, in the same cycle.
REQ-015 On each clk_in edge with wr_en_out=1, the binary write pointer wbin SHALL increment by 1 modulo 2^(ADDR_WIDTH+1); otherwise wbin SHALL hold.
REQ-016 wr_addr_out SHALL be wbin[ADDR_WIDTH-1:0] before the increment, so the RAM write uses the current address.
REQ-017 wr_ptr_gray_out SHALL be registered as (wbin_next >> 1) XOR wbin_next, updating in the same edge as wbin, with no combinational path from any input.
REQ-018 Successive values of wr_ptr_gray_out SHALL differ in exactly one bit, including across the wrap from all-ones to zero.
REQ-019 The block SHALL Gray-decode rd_ptr_gray_in to binary rbin: bit MSB is passed through; each lower bit i = XOR of Gray bits MSB down to i.
REQ-020 full_out SHALL be registered as (gray_next == {~rd_ptr_gray_in[MSB:MSB-1], rd_ptr_gray_in[MSB-2:0]}), where gray_next is the Gray code of wbin_next.
REQ-021 fill_level_out SHALL be registered as (wbin_next - rbin) modulo 2^(ADDR_WIDTH+1), with range 0 to 2^ADDR_WIDTH.
REQ-022 Read pointer advances SHALL deassert full_out and reduce fill_level_out one cycle after rd_ptr_gray_in changes.
REQ-023 A write attempted while full SHALL be dropped: wr_en_out=0, the pointers hold, and overflow_out is set to 1 on the next edge.
REQ-024 overflow_out SHALL remain set until rst_in.
REQ-025 If a write and a read-pointer change occur in the same cycle, both SHALL be reflected in full_out and fill_level_out on the next edge.
REQ-026 Read-pointer values that imply occupancy above 2^ADDR_WIDTH are illegal; the block SHALL not check for them.

Reset
REQ-027 While rst_in=1 at a clk_in edge, wbin, wr_ptr_gray_out, fill_level_out, full_out, overflow_out and almost_full_out SHALL all be cleared to 0.
REQ-028 wr_en_out SHALL be 0 during any cycle in which rst_in=1, regardless of wr_req_in.
REQ-029 A reset asserted mid-operation SHALL discard all pointer state; the read side is reset concurrently by system convention.

Configuration
REQ-030 With FIFO_WR_ALMOST_FULL_EN defined, almost_full_out SHALL be registered as (fill level computed per REQ-021 >= 2^ADDR_WIDTH - AF_THRESH).
REQ-031 Without FIFO_WR_ALMOST_FULL_EN, the almost_full_out port and its logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-032 Use ADDR_WIDTH=2 (depth 4) for the scenarios below.
REQ-033 Scenario 1: rd_ptr_gray_in=000, four writes -> wr_ptr_gray_out steps 001, 011, 010, 110; wr_addr_out steps 0, 1, 2, 3; full_out=1 and fill_level_out=4 after the 4th write.
REQ-034 Scenario 2: from full, wr_req_in=1 -> wr_en_out=0, wr_ptr_gray_out stays 110, overflow_out=1 from the next cycle and stays 1.
REQ-035 Scenario 3: from full, rd_ptr_gray_in becomes 001 -> full_out=0 and fill_level_out=3 one cycle later; the next write is accepted at address 0.
REQ-036 Scenario 4: 16 writes with rd_ptr_gray_in tracking one write behind -> each step of wr_ptr_gray_out has Hamming distance 1, including 100->000; full_out never asserts.
REQ-037 Scenario 5: rst_in asserted after 3 writes -> all outputs are 0 on the next edge; wr_en_out=0 while rst_in=1 even with wr_req_in=1.
REQ-038 Scenario 6: FIFO_WR_ALMOST_FULL_EN defined, AF_THRESH=1 -> almost_full_out rises with fill_level_out=3 and stays 1 at 4.
